// File: rtl/register_file_read_unit.sv
`default_nettype none
// ============================================================================
// Module      : register_file_read_unit
// Description : Register storage with two registered read ports, same-cycle
//               write-to-read bypass and a per-register pending scoreboard
//               that stalls reads of registers still awaiting writeback.
// Revision    : 1.0 - initial release
// ============================================================================

module register_file_read_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rfw,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_ra1,
    input  logic [ADDR_W-1:0] i_ra2,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    output logic              o_rvalid,
    input  logic              i_issue,
    input  logic [ADDR_W-1:0] i_issue_dst,
    output logic              o_stall
);

    localparam int c_NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [c_NREG];
    logic [c_NREG-1:0] r_pending;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              r_rvalid;

    logic [c_NREG-1:0] w_wr_sel;
    logic [c_NREG-1:0] w_iss_sel;
    logic              w_byp1;
    logic              w_byp2;
    logic              w_hit1;
    logic              w_hit2;
    logic              w_stall;
    logic              w_accept;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;

    // One-hot decode of the write and issue addresses.
    generate
        for (genvar gi = 0; gi < c_NREG; gi++) begin : g_dec
            localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(gi);
            assign w_wr_sel[gi]  = i_rfw   && (i_wa        == c_IDX);
            assign w_iss_sel[gi] = i_issue && (i_issue_dst == c_IDX);
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NREG; i++) begin
                if (w_wr_sel[i]) begin
                    r_regs[i] <= i_wd;
                end
            end
        end
    end

    // A same-edge issue overrides the writeback clear: a new producer is in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_wr_sel) | w_iss_sel;
        end
    end

    assign w_byp1   = i_rfw && (i_wa == i_ra1);
    assign w_byp2   = i_rfw && (i_wa == i_ra2);
    assign w_rdata1 = w_byp1 ? i_wd : r_regs[i_ra1];
    assign w_rdata2 = w_byp2 ? i_wd : r_regs[i_ra2];

    // A writeback landing this cycle satisfies the hazard through the bypass.
    assign w_hit1   = r_pending[i_ra1] && !w_byp1;
    assign w_hit2   = r_pending[i_ra2] && !w_byp2;
    assign w_stall  = i_re && (w_hit1 || w_hit2);
    assign w_accept = i_re && !w_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_accept;
            if (w_accept) begin
                r_rd1 <= w_rdata1;
                r_rd2 <= w_rdata2;
            end
        end
    end

    assign o_rd1    = r_rd1;
    assign o_rd2    = r_rd2;
    assign o_rvalid = r_rvalid;
    assign o_stall  = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_register_file_read_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_read_unit
// Description : Directed bench for register_file_read_unit with a reference
//               model checked every cycle plus hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_register_file_read_unit;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int c_NREG = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              rfw;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              re;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rvalid;
    logic              issue;
    logic [ADDR_W-1:0] issue_dst;
    logic              stall;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    register_file_read_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rfw      (rfw),
        .i_wa       (wa),
        .i_wd       (wd),
        .i_re       (re),
        .i_ra1      (ra1),
        .i_ra2      (ra2),
        .o_rd1      (rd1),
        .o_rd2      (rd2),
        .o_rvalid   (rvalid),
        .i_issue    (issue),
        .i_issue_dst(issue_dst),
        .o_stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents and outstanding-producer flags.
    logic [DATA_W-1:0] m_regs [c_NREG];
    bit                m_pend [c_NREG];
    logic [DATA_W-1:0] m_rd1 = '0;
    logic [DATA_W-1:0] m_rd2 = '0;
    bit                m_rv  = 1'b0;

    initial begin
        for (int i = 0; i < c_NREG; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    end

    function automatic logic [DATA_W-1:0] m_value(input logic [ADDR_W-1:0] a);
        if (rfw && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic bit m_blocked(input logic [ADDR_W-1:0] a);
        return m_pend[a] && !(rfw && wa == a);
    endfunction

    function automatic bit m_stall();
        return re && (m_blocked(ra1) || m_blocked(ra2));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NREG; i++) begin
                m_regs[i] <= '0;
                m_pend[i] <= 1'b0;
            end
            m_rd1 <= '0;
            m_rd2 <= '0;
            m_rv  <= 1'b0;
        end else begin
            if (re && !m_stall()) begin
                m_rd1 <= m_value(ra1);
                m_rd2 <= m_value(ra2);
                m_rv  <= 1'b1;
            end else begin
                m_rv  <= 1'b0;
            end
            if (rfw) begin
                m_regs[wa] <= wd;
                m_pend[wa] <= 1'b0;
            end
            if (issue) m_pend[issue_dst] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_stall",  32'(stall),  32'(m_stall()));
            check("model_rd1",    32'(rd1),    32'(m_rd1));
            check("model_rd2",    32'(rd2),    32'(m_rd2));
            check("model_rvalid", 32'(rvalid), 32'(m_rv));
        end
    end

    task automatic idle();
        rfw = 0; wa = '0; wd = '0; re = 0; ra1 = '0; ra2 = '0;
        issue = 0; issue_dst = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        check("reset_rd1",    32'(rd1),    32'h0);
        check("reset_rd2",    32'(rd2),    32'h0);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        check("reset_stall",  32'(stall),  32'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Load reg k = k*3, then read 5 and 2.
        for (int k = 0; k < c_NREG; k++) begin
            rfw = 1; wa = ADDR_W'(k); wd = DATA_W'(k * 3);
            cyc();
        end
        idle();
        re = 1; ra1 = 3'd5; ra2 = 3'd2;
        #1 check("load_stall", 32'(stall), 32'h0);
        cyc(); idle();
        check("load_rd1",    32'(rd1),    32'd15);
        check("load_rd2",    32'(rd2),    32'd6);
        check("load_rvalid", 32'(rvalid), 32'h1);
        cyc();
        check("load_rvalid_pulse", 32'(rvalid), 32'h0);

        // Same-cycle write bypass.
        rfw = 1; wa = 3'd3; wd = 16'h0011;
        cyc(); idle();
        rfw = 1; wa = 3'd3; wd = 16'hBEEF; re = 1; ra1 = 3'd3; ra2 = 3'd3;
        cyc(); idle();
        check("byp_rd1", 32'(rd1), 32'hBEEF);
        check("byp_rd2", 32'(rd2), 32'hBEEF);
        re = 1; ra1 = 3'd3; ra2 = 3'd0;
        cyc(); idle();
        check("byp_stored_rd1", 32'(rd1), 32'hBEEF);
        check("byp_stored_rd2", 32'(rd2), 32'h0);

        // Stall on a pending register, released by its writeback.
        issue = 1; issue_dst = 3'd4;
        cyc(); idle();
        re = 1; ra1 = 3'd4; ra2 = 3'd0;
        #1 check("stall_set", 32'(stall), 32'h1);
        cyc();
        check("stall_rvalid", 32'(rvalid), 32'h0);
        check("stall_rd1_hold", 32'(rd1), 32'hBEEF);
        rfw = 1; wa = 3'd4; wd = 16'h1234;
        #1 check("stall_release", 32'(stall), 32'h0);
        cyc(); idle();
        check("release_rd1",    32'(rd1),    32'h1234);
        check("release_rvalid", 32'(rvalid), 32'h1);
        re = 1; ra1 = 3'd4; ra2 = 3'd4;
        #1 check("pend4_cleared", 32'(stall), 32'h0);
        cyc(); idle();

        // Issue and write to the same register in one cycle: issue wins.
        issue = 1; issue_dst = 3'd6; rfw = 1; wa = 3'd6; wd = 16'h00AA;
        cyc(); idle();
        re = 1; ra1 = 3'd0; ra2 = 3'd6;
        for (int n = 0; n < 3; n++) begin
            #1 check("iss_wr_stall", 32'(stall), 32'h1);
            cyc();
            check("iss_wr_rvalid", 32'(rvalid), 32'h0);
        end
        rfw = 1; wa = 3'd6; wd = 16'h00AB;
        #1 check("iss_wr_release", 32'(stall), 32'h0);
        cyc(); idle();
        check("iss_wr_rd2", 32'(rd2), 32'h00AB);
        check("iss_wr_rd1", 32'(rd1), 32'h0);

        // Port independence: one pending source blocks the whole read.
        issue = 1; issue_dst = 3'd7;
        cyc(); idle();
        re = 1; ra1 = 3'd0; ra2 = 3'd7;
        #1 check("indep_stall", 32'(stall), 32'h1);
        cyc(); idle();
        check("indep_rvalid", 32'(rvalid), 32'h0);
        check("indep_rd2_hold", 32'(rd2), 32'h00AB);

        // Asynchronous reset while a read is stalled.
        rfw = 1; wa = 3'd1; wd = 16'h5555;
        cyc(); idle();
        re = 1; ra1 = 3'd1; ra2 = 3'd1;
        cyc(); idle();
        check("pre_rst_rd1", 32'(rd1), 32'h5555);
        issue = 1; issue_dst = 3'd1;
        cyc(); idle();
        re = 1; ra1 = 3'd1; ra2 = 3'd1;
        #1 check("pre_rst_stall", 32'(stall), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rd1",    32'(rd1),    32'h0);
        check("mid_rst_stall",  32'(stall),  32'h0);
        check("mid_rst_rvalid", 32'(rvalid), 32'h0);
        cyc();
        #1 rst_n = 1'b1;
        @(posedge clk); #1; idle();
        check("post_rst_rd1",    32'(rd1),    32'h0);
        check("post_rst_rvalid", 32'(rvalid), 32'h1);
        cyc(); cyc();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete, expected finish before 20000");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/register_file_read_unit.md
Name: register_file_read_unit

Overview:
- Storage and read side of the register file. Its write data comes from RegisterFileDataInputMux Output; this block is the consumer of that write path.
- Holds 2**ADDR_W words and provides two registered read ports with write-to-read bypass.
- Keeps a per-register pending scoreboard: while a source register awaits writeback, the read is stalled.
- Sits between the writeback mux and the ALU operand latches.

Parameters:
- DATA_W, 16, word width; matches the mux Output width.
- ADDR_W, 3, register address width; the file holds 8 registers.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous reset, active low.
- RFW  in  1  write enable for the writeback port.
- WA  in  ADDR_W  write address.
- WD  in  DATA_W  write data, driven from RegisterFileDataInputMux Output.
- RE  in  1  read request.
- RA1  in  ADDR_W  read port 1 address.
- RA2  in  ADDR_W  read port 2 address.
- RD1  out  DATA_W  registered read data, port 1.
- RD2  out  DATA_W  registered read data, port 2.
- RVALID  out  1  one-cycle pulse: RD1/RD2 were updated by an accepted read.
- ISSUE  in  1  marks a destination register as awaiting writeback.
- ISSUE_DST  in  ADDR_W  destination register being issued.
- STALL  out  1  combinational: the current read request cannot be accepted.

Behaviour:
- Reset (RST_N=0, asynchronous, takes effect mid-cycle):
  - all registers = 0; pending[*] = 0.
  - RD1 = RD2 = 0; RVALID = 0; STALL = 0.
  - Holds while RST_N is low. The first edge after release behaves normally.
- Write:
  - At an edge with RFW=1: reg[WA] <= WD and pending[WA] <= 0, unless the issue rule below applies.
  - Every register is writable; there is no hardwired zero.
- Scoreboard:
  - At an edge with ISSUE=1: pending[ISSUE_DST] <= 1.
  - Same edge with RFW=1 and WA==ISSUE_DST: the data is written and pending stays 1 (the issue wins; a new producer is outstanding).
  - Issuing an already-pending register leaves it 1; there is no count.
  - ISSUE is accepted regardless of STALL or RE.
- Hazard check:
  - hit1 = pending[RA1] and not (RFW and WA==RA1).
  - hit2 = pending[RA2] and not (RFW and WA==RA2).
  - STALL = RE and (hit1 or hit2).
  - A writeback in the same cycle clears the hazard through the bypass.
- Read (latency 1):
  - At an edge with RE=1 and STALL=0:
    - RD1 <= (RFW and WA==RA1) ? WD : reg[RA1]; RD2 is the same with RA2.
    - RVALID <= 1.
  - Otherwise RD1/RD2 hold their value and RVALID <= 0.
  - RA1==RA2 is legal; both ports return identical data.
  - The bypass applies only to the write in the same cycle as the read.
- The read path does not consider ISSUE/ISSUE_DST in the same cycle. Pending set by ISSUE at edge N first affects STALL after edge N.

Test Plan:
- Reset and readout:
  - Stimulus: RST_N low; write reg k = k*3 for k=0..7; RE with RA1=5, RA2=2.
  - Required: before the writes, RD1=RD2=0 and STALL=0; after the read edge, RD1=15, RD2=6, RVALID pulses once.
- Bypass:
  - Stimulus: reg3=0x0011; in one cycle RFW=1, WA=3, WD=0xBEEF, RE=1, RA1=3, RA2=3.
  - Required: next cycle RD1=RD2=0xBEEF and reg3=0xBEEF; with no bypass the result would be 0x0011 (fail).
- Stall then release:
  - Stimulus: ISSUE with ISSUE_DST=4; next cycle RE=1, RA1=4.
  - Required: STALL=1, RD1 holds, RVALID=0.
  - Then RFW=1, WA=4, WD=0x1234: in that cycle STALL=0; at the edge RD1=0x1234, RVALID=1, and pending[4] is cleared.
- Simultaneous issue and write:
  - Stimulus: ISSUE_DST=6 and RFW=1, WA=6, WD=0x00AA in the same cycle; then RE with RA2=6.
  - Required: reg6=0x00AA but STALL=1 until the next write to reg 6.
- Reset mid-operation:
  - Stimulus: pending[1]=1, stalled read on RA1=1, RD1=0x5555; drop RST_N between edges.
  - Required: RD1=0, STALL=0, RVALID=0 immediately without a clock edge; after release, a read of reg1 returns 0.
- Port independence:
  - Stimulus: RA1=0 (not pending), RA2=7 (pending).
  - Required: STALL=1 and neither port updates, since accepted reads are all-or-nothing.
